// File: rtl/profile_ci.sv
// Custom-instruction profiling unit: four 32-bit event counters (cycles, stall,
// bus-idle, executing) that are controlled and read back through one CI.
module profile_ci #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        busIdle,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  logic [3:0]  r_en;
  logic [31:0] r_cnt0;
  logic [31:0] r_cnt1;
  logic [31:0] r_cnt2;
  logic [31:0] r_cnt3;

  logic        w_sel;
  logic [3:0]  w_event;
  logic [3:0]  w_inc;
  logic [3:0]  w_clr;
  logic [3:0]  w_en_next;
  logic        w_unused;

  // Clear beats increment; otherwise count by one, wrapping modulo 2^32.
  function automatic logic [31:0] f_cnt_next(input logic [31:0] cnt,
                                             input logic        clr,
                                             input logic        inc);
    logic [31:0] nxt;
    if (clr) begin
      nxt = 32'd0;
    end else if (inc) begin
      nxt = cnt + 32'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  assign w_sel    = start && (ciN == customId);
  assign w_event  = {~stall, busIdle, stall, 1'b1};
  // Gating with the enable keeps X on an unused event input away from the counter.
  assign w_inc    = r_en & w_event;
  assign w_clr    = w_sel ? valueB[11:8] : 4'b0000;
  assign w_unused = ^{valueA[31:2], valueB[31:12]};

  always_comb begin
    w_en_next = r_en;
    if (w_sel) begin
      w_en_next = (r_en | valueB[3:0]) & ~valueB[7:4];
    end else begin
      w_en_next = r_en;
    end
  end

  always_comb begin
    done   = w_sel;
    result = 32'd0;
    if (w_sel) begin
      case (valueA[1:0])
        2'd0:    result = r_cnt0;
        2'd1:    result = r_cnt1;
        2'd2:    result = r_cnt2;
        2'd3:    result = r_cnt3;
        default: result = 32'd0;
      endcase
    end else begin
      result = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_en   <= 4'b0000;
      r_cnt0 <= 32'd0;
      r_cnt1 <= 32'd0;
      r_cnt2 <= 32'd0;
      r_cnt3 <= 32'd0;
    end else begin
      r_en   <= w_en_next;
      r_cnt0 <= f_cnt_next(r_cnt0, w_clr[0], w_inc[0]);
      r_cnt1 <= f_cnt_next(r_cnt1, w_clr[1], w_inc[1]);
      r_cnt2 <= f_cnt_next(r_cnt2, w_clr[2], w_inc[2]);
      r_cnt3 <= f_cnt_next(r_cnt3, w_clr[3], w_inc[3]);
    end
  end

endmodule

// File: tb/tb_profile_ci.sv
// Directed self-checking bench for profile_ci (customId = 8'h08).
module tb_profile_ci;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        busIdle;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  profile_ci #(.customId(8'h08)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .stall  (stall),
    .busIdle(busIdle),
    .valueA (valueA),
    .valueB (valueB),
    .ciN    (ciN),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  // Every cycle: inputs driven at the falling edge, outputs checked 1 ns later.
  task automatic drive(input logic st, input logic [7:0] n, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic bi);
    start = st; ciN = n; valueA = a; valueB = b; stall = s; busIdle = bi;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; ciN = 8'h00; valueA = 32'd0; valueB = 32'd0;
    stall = 1'b0; busIdle = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 8'h08, 32'd0, 32'd0, 1'b0, 1'b0);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done_nostart: got %b want 0", done); end
    n_cmp++;
    if (result !== 32'd0) begin n_err++; $display("FAIL reset_result_nostart: got %h want 0", result); end
    @(negedge clock);
  endtask

  task automatic test_foreign_id();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h11, 32'd0, 32'h0E1, 1'b0, 1'b0);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL foreign_done[%0d]: got %b want 0", i, done); end
      n_cmp++;
      if (result !== 32'd0) begin n_err++; $display("FAIL foreign_result[%0d]: got %h want 0", i, result); end
      @(negedge clock);
    end
  endtask

  // Enable counter 0; it starts counting one edge after the enable is written.
  task automatic test_enable_cnt0();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h08, 32'd0, 32'h0E1, 1'b0, 1'b0);
      n_cmp++;
      if (done !== 1'b1) begin n_err++; $display("FAIL cnt0_done[%0d]: got %b want 1", i, done); end
      n_cmp++;
      if (result !== ((i == 0) ? 32'd0 : 32'(i - 1))) begin
        n_err++; $display("FAIL cnt0_value[%0d]: got %0d want %0d", i, result, (i == 0) ? 0 : i - 1);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_ignore_control();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h11, 32'd0, 32'hFFF, 1'b0, 1'b0);
      n_cmp++;
      if ((done !== 1'b0) || (result !== 32'd0)) begin
        n_err++; $display("FAIL ignore_ctrl[%0d]: got done=%b result=%h want 0/0", i, done, result);
      end
      @(negedge clock);
    end
    drive(1'b1, 8'h08, 32'd0, 32'h000, 1'b0, 1'b0);
    n_cmp++;
    if (result !== 32'd11) begin n_err++; $display("FAIL cnt0_after_ignore: got %0d want 11", result); end
    @(negedge clock);
  endtask

  task automatic test_stall_cnt1();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h08, 32'd1, 32'h0C3, 1'b1, 1'b0);
      n_cmp++;
      if (result !== ((i == 0) ? 32'd0 : 32'(i - 1))) begin
        n_err++; $display("FAIL cnt1_value[%0d]: got %0d want %0d", i, result, (i == 0) ? 0 : i - 1);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_busidle_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h08, 32'd2, 32'h187, 1'b1, 1'b1);
      n_cmp++;
      if (result !== ((i == 0) ? 32'd0 : 32'(i - 1))) begin
        n_err++; $display("FAIL cnt2_value[%0d]: got %0d want %0d", i, result, (i == 0) ? 0 : i - 1);
      end
      @(negedge clock);
    end
    drive(1'b1, 8'h08, 32'd0, 32'h000, 1'b1, 1'b1);
    n_cmp++;
    if (result !== 32'd0) begin n_err++; $display("FAIL cnt0_cleared: got %0d want 0", result); end
    @(negedge clock);
    drive(1'b1, 8'h08, 32'd0, 32'h000, 1'b1, 1'b1);
    n_cmp++;
    if (result !== 32'd1) begin n_err++; $display("FAIL cnt0_en_kept: got %0d want 1", result); end
    @(negedge clock);
    drive(1'b1, 8'h08, 32'd1, 32'h000, 1'b0, 1'b0);
    n_cmp++;
    if (result !== 32'd11) begin n_err++; $display("FAIL cnt1_total: got %0d want 11", result); end
    @(negedge clock);
  endtask

  task automatic test_wrap_priority();
    logic [31:0] exp_wrap [4];
    exp_wrap[0] = 32'hFFFF_FFFE; exp_wrap[1] = 32'hFFFF_FFFF;
    exp_wrap[2] = 32'd0;         exp_wrap[3] = 32'd1;
    drive(1'b1, 8'h08, 32'd3, 32'h008, 1'b0, 1'b0);
    n_cmp++;
    if (result !== 32'd0) begin n_err++; $display("FAIL cnt3_initial: got %h want 0", result); end
    @(negedge clock);
    force dut.r_cnt3 = 32'hFFFF_FFFE;
    #1;
    release dut.r_cnt3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h08, 32'd3, 32'h000, 1'b0, 1'b0);
      n_cmp++;
      if (result !== exp_wrap[i]) begin
        n_err++; $display("FAIL cnt3_wrap[%0d]: got %h want %h", i, result, exp_wrap[i]);
      end
      @(negedge clock);
    end
    // Enable and disable together: the edge still counts (old enable), then stops.
    drive(1'b1, 8'h08, 32'd3, 32'h088, 1'b0, 1'b0);
    n_cmp++;
    if (result !== 32'd2) begin n_err++; $display("FAIL cnt3_en_dis: got %0d want 2", result); end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h08, 32'd3, 32'h000, 1'b0, 1'b0);
      n_cmp++;
      if (result !== 32'd3) begin n_err++; $display("FAIL cnt3_disabled[%0d]: got %0d want 3", i, result); end
      @(negedge clock);
    end
  endtask

  // Reset mid-count with an enable-all CI in the same cycle; reset must win.
  task automatic test_reset_midcount();
    reset = 1'b1;
    drive(1'b1, 8'h08, 32'd0, 32'h00F, 1'b1, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h08, 32'd0, 32'h000, 1'b1, 1'b1);
      n_cmp++;
      if (result !== 32'd0) begin n_err++; $display("FAIL rst_cnt0[%0d]: got %0d want 0", i, result); end
      @(negedge clock);
    end
    drive(1'b1, 8'h08, 32'd2, 32'h000, 1'b1, 1'b1);
    n_cmp++;
    if (result !== 32'd0) begin n_err++; $display("FAIL rst_cnt2: got %0d want 0", result); end
    @(negedge clock);
    drive(1'b1, 8'h08, 32'd1, 32'h000, 1'b1, 1'b1);
    n_cmp++;
    if (result !== 32'd0) begin n_err++; $display("FAIL rst_cnt1: got %0d want 0", result); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_foreign_id();
    test_enable_cnt0();
    test_ignore_control();
    test_stall_cnt1();
    test_busidle_clear();
    test_wrap_priority();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
